// File: rtl/mult_accum.sv
// Fixed-latency accumulator: sums LEN consecutive terms started by go
// and presents the registered total for one cycle, LEN cycles later.
module mult_accum #(
    parameter int WIDTH = 32,
    parameter int LEN   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy
);

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST  = CW'(LEN - 1);
    localparam logic [CW-1:0] FIRST = (LEN > 1) ? CW'(1) : '0;

    generate
        if (LEN < 1 || LEN > 65535) begin : g_bad_len
            $error("mult_accum: LEN must be in 1..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (go) begin
                    next_state = (LEN > 1) ? ACC : DONE;
                end
            end
            ACC: begin
                if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                // A go here restarts immediately, giving one result per LEN cycles
                if (go) begin
                    next_state = (LEN > 1) ? ACC : DONE;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == ACC) begin
            acc <= acc + in;
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end else if (go) begin
            acc <= in;
            cnt <= FIRST;
        end
    end

    assign out       = acc;
    assign out_valid = (state == DONE);
    assign busy      = (state == ACC);

endmodule

// File: tb/tb_mult_accum.sv
// Bench for mult_accum: directed table, hand sequences, and random
// traffic against a term-counting reference model.
module tb_mult_accum;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0;
    logic [31:0] in_d = '0;
    logic [31:0] out;
    logic        out_valid;
    logic        busy;

    logic        r1 = 1'b0;
    logic        g1 = 1'b0;
    logic [31:0] d1 = '0;
    logic [31:0] out1;
    logic        v1;
    logic        b1;

    always #5 clk = ~clk;

    mult_accum #(.WIDTH(32), .LEN(LEN)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (go),
        .in       (in_d),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy)
    );

    mult_accum #(.WIDTH(32), .LEN(1)) u_dut1 (
        .clk      (clk),
        .reset_n  (r1),
        .go       (g1),
        .in       (d1),
        .out      (out1),
        .out_valid(v1),
        .busy     (b1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: terms still owed by the current run and their sum
    int          rem = 0;
    logic [31:0] msum = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_out = '0;

    typedef struct {
        logic        g;
        logic [31:0] d;
        logic        v;
        logic        b;
        logic [31:0] o;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic g, input logic [31:0] d, input logic v,
                       input logic b, input logic [31:0] o);
        vec_t r;
        r.g = g;
        r.d = d;
        r.v = v;
        r.b = b;
        r.o = o;
        tbl.push_back(r);
    endtask

    task automatic step(input logic g, input logic [31:0] d, input logic r);
        go      = g;
        in_d    = d;
        reset_n = r;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        if (!r) begin
            rem  = 0;
            msum = '0;
        end else if (rem > 0) begin
            msum = msum + d;
            rem--;
            if (rem == 0) begin
                m_valid = 1'b1;
                m_out   = msum;
            end
        end else if (g) begin
            msum = d;
            rem  = LEN - 1;
            if (rem == 0) begin
                m_valid = 1'b1;
                m_out   = msum;
            end
        end
        chk("model_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("model_busy", {31'b0, busy}, {31'b0, rem > 0});
        if (m_valid) chk("model_out", out, m_out);
        if (!r) chk("reset_out", out, 32'h0);
    endtask

    initial begin
        logic [31:0] seq1 [3];

        // Reset held with go asserted
        step(1'b1, 32'd5, 1'b0);
        step(1'b1, 32'd5, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        chk("idle_after_reset_out", out, 32'h0);

        // Basic sum
        add(1, 1, 0, 1, 0); add(0, 2, 0, 1, 0);
        add(0, 3, 0, 1, 0); add(0, 4, 1, 0, 10);
        add(0, 0, 0, 0, 0);
        // Back-to-back, go again in the DONE cycle
        add(1, 1, 0, 1, 0); add(0, 1, 0, 1, 0);
        add(0, 1, 0, 1, 0); add(0, 1, 1, 0, 4);
        add(1, 2, 0, 1, 0); add(0, 2, 0, 1, 0);
        add(0, 2, 0, 1, 0); add(0, 2, 1, 0, 8);
        add(0, 0, 0, 0, 0);
        // Wrap-around
        add(1, 32'hFFFFFFFF, 0, 1, 0); add(0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0); add(0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0);
        add(1, 32'hFFFFFFFF, 0, 1, 0); add(0, 32'hFFFFFFFF, 0, 1, 0);
        add(0, 32'hFFFFFFFF, 0, 1, 0);
        add(0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFC);
        add(0, 0, 0, 0, 0);
        // go pulsed mid-accumulation is ignored
        add(1, 5, 0, 1, 0); add(0, 6, 0, 1, 0);
        add(1, 7, 0, 1, 0); add(0, 8, 1, 0, 26);
        add(0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].g, tbl[i].d, 1'b1);
            chk("tbl_valid", {31'b0, out_valid}, {31'b0, tbl[i].v});
            chk("tbl_busy", {31'b0, busy}, {31'b0, tbl[i].b});
            if (tbl[i].v) chk("tbl_out", out, tbl[i].o);
        end

        // Mid-operation reset discards the partial sum
        step(1'b1, 32'd1, 1'b1);
        step(1'b0, 32'd2, 1'b1);
        step(1'b0, 32'd3, 1'b0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'd0, 1'b1);
            chk("midrst_novalid", {31'b0, out_valid}, 32'h0);
        end
        step(1'b1, 32'd10, 1'b1);
        step(1'b0, 32'd20, 1'b1);
        step(1'b0, 32'd30, 1'b1);
        step(1'b0, 32'd40, 1'b1);
        chk("midrst_valid", {31'b0, out_valid}, 32'h1);
        chk("midrst_sum", out, 32'd100);
        step(1'b0, 32'd0, 1'b1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        g;
            logic [31:0] d;
            r = ($urandom_range(0, 49) != 0);
            g = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step(g, d, r);
        end

        // LEN=1 build: continuous go gives a result every cycle
        seq1[0] = 32'd7;
        seq1[1] = 32'd8;
        seq1[2] = 32'd9;
        r1 = 1'b0;
        @(posedge clk);
        #1;
        chk("len1_reset_valid", {31'b0, v1}, 32'h0);
        r1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            g1 = 1'b1;
            d1 = seq1[i];
            @(posedge clk);
            #1;
            chk("len1_valid", {31'b0, v1}, 32'h1);
            chk("len1_out", out1, seq1[i]);
            chk("len1_busy", {31'b0, b1}, 32'h0);
        end
        g1 = 1'b0;
        @(posedge clk);
        #1;
        chk("len1_idle", {31'b0, v1}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
